hazard_stall_controller: RTL and testbench
==========================================

// Module: hazard_stall_controller
// PURPOSE
//   Pipeline sequencer for the 5-stage RISC-V core; sits beside the operand-forwarding logic.
//   - Covers the hazards that forwarding cannot hide:
//     - load-use: inserts a bubble;
//     - taken branch or jump: flushes for FLUSH_CYCLES;
//     - multi-cycle MUL/DIV: holds the pipe until the unit hands back.
//   - Drives the pipeline-register write enables and flushes, plus the MUL/DIV start handshake.
// PARAMETERS
//   FLUSH_CYCLES  1   cycles IF/ID is flushed after a taken branch (1..4)
//   MD_TIMEOUT    64  max MD_WAIT cycles before abort (>=2, counter width = $clog2(MD_TIMEOUT)+1)
// PORTS
//   clk             in   1  rising-edge clock
//   rst             in   1  asynchronous, active-high reset
//   id_rs1          in   5  rs1 of instruction in ID
//   id_rs2          in   5  rs2 of instruction in ID
//   id_uses_rs1     in   1  ID instruction reads rs1
//   id_uses_rs2     in   1  ID instruction reads rs2
//   idex_mem_read   in   1  instruction in EX is a load
//   idex_rd         in   5  destination register of EX instruction
//   ex_branch_taken in   1  branch/jump in EX resolved taken
//   ex_is_muldiv    in   1  instruction in EX is MUL/DIV
//   md_done         in   1  MUL/DIV result valid, one-cycle pulse
//   pc_write        out  1  PC update enable
//   if_id_write     out  1  IF/ID register enable
//   if_id_flush     out  1  IF/ID clear to NOP
//   id_ex_write     out  1  ID/EX register enable
//   id_ex_flush     out  1  ID/EX clear to NOP (bubble)
//   ex_mem_bubble   out  1  load NOP into EX/MEM
//   md_start        out  1  one-cycle MUL/DIV start pulse
//   md_err          out  1  sticky: MUL/DIV timeout occurred
//   busy            out  1  FSM not in RUN
// BEHAVIOUR
//   - FSM states: RUN, FLUSH, MD_WAIT. Reset (async) -> RUN, counters 0, md_err 0.
//   - While rst is high: pc_write, if_id_write, id_ex_write = 0; every other output = 0.
//   - RUN, no hazard: pc_write, if_id_write, id_ex_write = 1; flushes, bubble, md_start = 0.
//   - Priority in RUN, highest first: branch > muldiv > load-use.
//   - Branch (RUN, ex_branch_taken = 1), same cycle:
//     - if_id_flush = 1, id_ex_flush = 1, pc_write = 1 (the target loads).
//     - If FLUSH_CYCLES > 1: -> FLUSH, cnt = FLUSH_CYCLES-1.
//     - Otherwise stay in RUN.
//   - FLUSH: if_id_flush = 1, id_ex_flush = 1, pc_write = 1; cnt decrements; cnt == 1 -> RUN.
//   - Muldiv start (RUN, ex_is_muldiv = 1), same cycle:
//     - md_start = 1; pc_write, if_id_write, id_ex_write = 0; ex_mem_bubble = 1.
//     - -> MD_WAIT, wcnt = 0.
//   - MD_WAIT: same hold/bubble as muldiv start, but md_start = 0; wcnt increments each cycle.
//   - Leaving MD_WAIT:
//     - md_done = 1: this cycle releases all holds (writes = 1, ex_mem_bubble = 0) so the result latches; -> RUN.
//     - wcnt == MD_TIMEOUT-1 with no md_done: set md_err, release as for md_done, -> RUN.
//     - md_done and timeout in the same cycle: done wins, md_err is not set.
//   - Load-use (RUN only): triggers when idex_mem_read = 1, idex_rd != 0, and rd matches
//     (rd == id_rs1 and id_uses_rs1) or (rd == id_rs2 and id_uses_rs2).
//     - Response: pc_write = 0, if_id_write = 0, id_ex_flush = 1 for exactly one cycle.
//     - Purely combinational; the next cycle clears naturally.
//   - ex_branch_taken and load-use are ignored in MD_WAIT.
//   - md_done is ignored outside MD_WAIT.
//   - Back-to-back MUL/DIV: RUN re-detects on the cycle after release and starts again.
//   - rst asserted mid-FLUSH or mid-MD_WAIT: immediate return to RUN; md_start is not re-issued.
//   - busy = (state != RUN).
// CONFIGURATION
//   HAZARD_STALL_STATS_EN defined:
//     - Adds outputs stat_ld_stalls [31:0], stat_flush_cycles [31:0], stat_md_cycles [31:0].
//     - Each is a saturating count of load-use, flush and MD_WAIT/start cycles; all reset to 0.
//   HAZARD_STALL_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//   - Reset release: check pc_write = 1, if_id_write = 1, id_ex_write = 1, busy = 0, md_err = 0.
//   - Load-use:
//     - Stimulus: idex_mem_read = 1, idex_rd = 5, id_rs2 = 5, id_uses_rs2 = 1.
//     - Expect one cycle of pc_write = 0, if_id_write = 0, id_ex_flush = 1.
//     - Repeat with idex_rd = 0: expect no stall.
//   - FLUSH_CYCLES = 3, ex_branch_taken pulse: expect if_id_flush = 1 for 3 consecutive cycles,
//     busy = 1 for cycles 2-3, then RUN.
//   - Priority: ex_branch_taken = 1 with a load-use match in the same cycle: expect branch flush only, pc_write = 1.
//   - MUL/DIV handshake:
//     - Stimulus: ex_is_muldiv = 1, md_done after 5 cycles.
//     - Expect md_start for 1 cycle, holds for 5 cycles, release on the md_done cycle, md_err = 0.
//   - MD_TIMEOUT = 8, no md_done: expect release and md_err = 1 at wait cycle 8.
//     Then assert rst mid-MD_WAIT: expect RUN and md_err = 0.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Pipeline stall/flush sequencer: load-use bubbles, branch flushes, MUL/DIV holds.
// Optional HAZARD_STALL_STATS_EN adds saturating hazard statistics counters.
module hazard_stall_controller #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MD_TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        idex_mem_read,
  input  logic [4:0]  idex_rd,
  input  logic        ex_branch_taken,
  input  logic        ex_is_muldiv,
  input  logic        md_done,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_write,
  output logic        id_ex_flush,
  output logic        ex_mem_bubble,
  output logic        md_start,
  output logic        md_err,
`ifdef HAZARD_STALL_STATS_EN
  output logic [31:0] stat_ld_stalls,
  output logic [31:0] stat_flush_cycles,
  output logic [31:0] stat_md_cycles,
`endif
  output logic        busy
);

  localparam int WW = $clog2(MD_TIMEOUT) + 1;

  typedef enum logic [1:0] {RUN, FLUSH, MD_WAIT} state_t;

  state_t        state, nextState;
  logic [2:0]    cnt, cntNext;
  logic [WW-1:0] wcnt, wcntNext;
  logic          mdErr, mdErrNext;
  logic          ldUse, mdGo, luGo;

  assign ldUse = idex_mem_read && (idex_rd != 5'd0) &&
                 (((idex_rd == id_rs1) && id_uses_rs1) ||
                  ((idex_rd == id_rs2) && id_uses_rs2));

  // Mutually exclusive hazard picks encode branch > muldiv > load-use.
  assign mdGo = ex_is_muldiv && !ex_branch_taken;
  assign luGo = ldUse && !ex_is_muldiv && !ex_branch_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
      wcnt  <= '0;
      mdErr <= 1'b0;
    end else begin
      state <= nextState;
      cnt   <= cntNext;
      wcnt  <= wcntNext;
      mdErr <= mdErrNext;
    end
  end

  always_comb begin
    nextState     = state;
    cntNext       = cnt;
    wcntNext      = wcnt;
    mdErrNext     = mdErr;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    md_start      = 1'b0;
    unique case (state)
      RUN: begin
        unique case (1'b1)
          ex_branch_taken: begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              nextState = FLUSH;
              cntNext   = 3'(FLUSH_CYCLES - 1);
            end
          end
          mdGo: begin
            md_start      = 1'b1;
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            nextState     = MD_WAIT;
            wcntNext      = '0;
          end
          luGo: begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end
          default: ;
        endcase
      end
      FLUSH: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        cntNext     = cnt - 3'd1;
        if (cnt == 3'd1) nextState = RUN;
      end
      MD_WAIT: begin
        if (md_done) begin
          nextState = RUN;
        end else if (wcnt == WW'(MD_TIMEOUT - 1)) begin
          mdErrNext = 1'b1;
          nextState = RUN;
        end else begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          wcntNext      = wcnt + WW'(1);
        end
      end
      default: nextState = RUN;
    endcase
    if (rst) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_write   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_bubble = 1'b0;
      md_start      = 1'b0;
    end
  end

  assign md_err = mdErr && !rst;
  assign busy   = (state != RUN) && !rst;

`ifdef HAZARD_STALL_STATS_EN
  logic ldEv, flEv, mdEv;

  assign ldEv = (state == RUN) && luGo;
  assign flEv = if_id_flush;
  assign mdEv = md_start || (state == MD_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ld_stalls    <= '0;
      stat_flush_cycles <= '0;
      stat_md_cycles    <= '0;
    end else begin
      if (ldEv && stat_ld_stalls != '1)
        stat_ld_stalls <= stat_ld_stalls + 32'd1;
      if (flEv && stat_flush_cycles != '1)
        stat_flush_cycles <= stat_flush_cycles + 32'd1;
      if (mdEv && stat_md_cycles != '1)
        stat_md_cycles <= stat_md_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller (FLUSH_CYCLES=3, MD_TIMEOUT=8).
// Output word: {pc_w, ifid_w, ifid_f, idex_w, idex_f, bubble, md_start, md_err, busy}.
module tb_hazard_stall_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, idex_rd;
  logic       id_uses_rs1, id_uses_rs2, idex_mem_read;
  logic       ex_branch_taken, ex_is_muldiv, md_done;
  logic       pc_write, if_id_write, if_id_flush, id_ex_write;
  logic       id_ex_flush, ex_mem_bubble, md_start, md_err, busy;
`ifdef HAZARD_STALL_STATS_EN
  logic [31:0] stat_ld_stalls, stat_flush_cycles, stat_md_cycles;
`endif

  always #5 clk = ~clk;

  hazard_stall_controller #(.FLUSH_CYCLES(3), .MD_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_is_muldiv(ex_is_muldiv),
    .md_done(md_done),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_write(id_ex_write),
    .id_ex_flush(id_ex_flush), .ex_mem_bubble(ex_mem_bubble),
    .md_start(md_start), .md_err(md_err),
`ifdef HAZARD_STALL_STATS_EN
    .stat_ld_stalls(stat_ld_stalls),
    .stat_flush_cycles(stat_flush_cycles),
    .stat_md_cycles(stat_md_cycles),
`endif
    .busy(busy)
  );

  localparam logic [8:0] RSTV = 9'b000000000;
  localparam logic [8:0] NORM = 9'b110100000;
  localparam logic [8:0] NERR = 9'b110100010;
  localparam logic [8:0] LU   = 9'b000110000;
  localparam logic [8:0] BR   = 9'b111110000;
  localparam logic [8:0] FLB  = 9'b111110001;
  localparam logic [8:0] MDS  = 9'b000001100;
  localparam logic [8:0] MDW  = 9'b000001001;
  localparam logic [8:0] MDR  = 9'b110100001;

  typedef struct {
    string      tag;
    logic [8:0] exp;
  } sbEntry_t;

  sbEntry_t sb[$];
  int nVec = 0;
  int nBad = 0;

  task automatic chk(input string tag, input logic [8:0] got,
                     input logic [8:0] exp);
    nVec++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sbEntry_t e;
      e = sb.pop_front();
      chk(e.tag, {pc_write, if_id_write, if_id_flush, id_ex_write,
                  id_ex_flush, ex_mem_bubble, md_start, md_err, busy},
          e.exp);
    end
  end

  task automatic cyc(input string tag, input logic [8:0] exp);
    sbEntry_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; idex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; idex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; ex_is_muldiv = 1'b0; md_done = 1'b0;
  endtask

  task automatic setLu();
    idex_mem_read = 1'b1; idex_rd = 5'd5;
    id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    cyc("rst", RSTV);
    ex_branch_taken = 1'b1; ex_is_muldiv = 1'b1;
    cyc("rst_inputs", RSTV);
    idle(); rst = 1'b0;
    cyc("rel", NORM);

    setLu();
    cyc("ldu_rs2", LU);
    idle();
    cyc("ldu_clear", NORM);
    idex_mem_read = 1'b1; idex_rd = 5'd7;
    id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
    cyc("ldu_rs1", LU);
    id_uses_rs1 = 1'b0;
    cyc("ldu_nouse", NORM);
    idle(); idex_mem_read = 1'b1;
    id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
    cyc("ldu_x0", NORM);
    idle();

    setLu(); ex_branch_taken = 1'b1;
    cyc("br_prio", BR);
    idle();
    cyc("flush2", FLB);
    cyc("flush3", FLB);
    cyc("flush_end", NORM);

    md_done = 1'b1;
    cyc("done_in_run", NORM);
    idle();
    ex_is_muldiv = 1'b1;
    cyc("md_start", MDS);
    for (int i = 0; i < 4; i++) begin
      ex_branch_taken = (i == 1);
      if (i == 2) setLu();
      cyc($sformatf("md_hold%0d", i), MDW);
    end
    idle(); ex_is_muldiv = 1'b1; md_done = 1'b1;
    cyc("md_release", MDR);
    md_done = 1'b0;
    cyc("md_b2b", MDS);
    md_done = 1'b1;
    cyc("md_b2b_rel", MDR);
    idle();
    cyc("md_after", NORM);

    ex_is_muldiv = 1'b1;
    cyc("to_start_a", MDS);
    for (int i = 0; i < 7; i++)
      cyc($sformatf("to_a_w%0d", i), MDW);
    idle(); md_done = 1'b1;
    cyc("done_vs_to", MDR);
    idle();
    cyc("no_err", NORM);

    ex_is_muldiv = 1'b1;
    cyc("to_start_b", MDS);
    ex_is_muldiv = 1'b0;
    for (int i = 0; i < 7; i++)
      cyc($sformatf("to_b_w%0d", i), MDW);
    cyc("to_release", MDR);
    cyc("err_set", NERR);
    cyc("err_sticky", NERR);

    ex_is_muldiv = 1'b1;
    cyc("rst_md_start", 9'b000001110);
    ex_is_muldiv = 1'b0;
    cyc("rst_md_wait", 9'b000001011);
    rst = 1'b1;
    cyc("rst_mid_md", RSTV);
    rst = 1'b0;
    cyc("rst_md_run", NORM);

    ex_branch_taken = 1'b1;
    cyc("rst_br", BR);
    ex_branch_taken = 1'b0;
    cyc("rst_fl2", FLB);
    rst = 1'b1;
    cyc("rst_mid_fl", RSTV);
    rst = 1'b0;
    cyc("rst_fl_run", NORM);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      nBad++;
      $display("FAIL drain: %0d left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
